// File: rtl/seq_multiplier_8x8.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One WIDTH-bit add-with-carry step per cycle; the carry is shifted back into the
// upper accumulator half, so the result is always exact.
// Operands are taken on a valid/ready handshake in IDLE. The product is held in DONE
// until it is consumed.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand goes straight from IDLE
// to DONE (1-cycle latency) instead of running the WIDTH-step loop.
module seq_multiplier_8x8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   step_sum;   // {carry, sum} of the current partial-product add
  logic             accept;
  logic             last_step;
  logic             zero_op;

  // Partial-product add: add the multiplicand only when the current multiplier LSB is set
  always_comb begin
    step_sum = {1'b0, acc_q};
    if (mplier_q[0]) begin
      step_sum = {1'b0, acc_q} + {1'b0, mcand_q};
    end
  end

  // Handshake and step bookkeeping decoded from the current state
  always_comb begin
    accept    = in_valid && (state_q == StIdle);
    last_step = (cnt_q == LastCnt);
    zero_op   = (a == '0) || (b == '0);
  end

  // Single FSM + datapath register block; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op) begin
              // Product is known to be zero; skip the shift loop entirely
              mplier_q <= '0;
              state_q  <= StDone;
            end else begin
              state_q  <= StCalc;
            end
`else
            state_q  <= StCalc;
`endif
          end
        end
        StCalc: begin
          // Right shift of {carry, sum, multiplier}: the carry lands in acc MSB
          {acc_q, mplier_q} <= {step_sum, mplier_q[WIDTH-1:1]};
          cnt_q             <= cnt_q + 1'b1;
          if (last_step) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status outputs are pure state decodes; product is a direct view of the registers
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StCalc) || (state_q == StDone);
    product   = {acc_q, mplier_q};
  end

`ifndef MULT_ZERO_BYPASS_EN
  // zero_op only steers the bypass build
  logic unused_zero_op;
  assign unused_zero_op = zero_op;
`endif

endmodule
